// File: rtl/fifo_rd_burst_sched_pkg.sv
// Shared types and helpers for the async FIFO read-domain scheduler.
// Provides the scheduler state enum, default address width and gray-code helpers.
package fifo_rd_burst_sched_pkg;

    localparam int ADDR_W_DEF = 9;
    // Helpers work on a wide container; callers cast to their pointer width.
    localparam int GW = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_e;

    function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down, done in log2 steps.
    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b = g;
        for (int s = 1; s < GW; s = s << 1) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_burst_sched_if.sv
// Read-port bundle between the FIFO read scheduler and its consumers/RAM.
// master: drives wptr_s/req/burst_len; slave (scheduler): drives grant..level.
interface fifo_rd_burst_sched_if
    import fifo_rd_burst_sched_pkg::*;
#(
    parameter int Addr_Width = ADDR_W_DEF,
    parameter int NUM_REQ    = 2,
    parameter int BURST_W    = 4
);
    logic [Addr_Width:0]         wptr_s;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*BURST_W-1:0]  burst_len;
    logic [NUM_REQ-1:0]          grant;
    logic                        ren;
    logic [Addr_Width-1:0]       raddr;
    logic [Addr_Width:0]         rptr;
    logic                        rempty;
    logic                        rd_valid;
    logic [NUM_REQ-1:0]          rd_owner;
    logic [Addr_Width:0]         level;

    modport master (
        output wptr_s, req, burst_len,
        input  grant, ren, raddr, rptr, rempty,
        input  rd_valid, rd_owner, level
    );

    modport slave (
        input  wptr_s, req, burst_len,
        output grant, ren, raddr, rptr, rempty,
        output rd_valid, rd_owner, level
    );
endinterface

// File: rtl/fifo_rd_burst_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after the last winner.
// req_i: requests, last_i: one-hot last winner, gnt_o: one-hot winner (0 if no request).
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] last_i,
    output logic [NUM_REQ-1:0] gnt_o
);
    logic [NUM_REQ-1:0] one;
    logic [NUM_REQ-1:0] thr;
    logic [NUM_REQ-1:0] hi;
    logic [NUM_REQ-1:0] pick;

    assign one  = NUM_REQ'(1);
    // thr-one masks positions at or below the last winner; MSB winner masks all.
    assign thr  = last_i << 1;
    assign hi   = req_i & ~(thr - one);
    assign pick = (|hi) ? hi : req_i;
    // Isolate lowest set bit.
    assign gnt_o = pick & (~pick + one);
endmodule

// File: rtl/fifo_rd_burst_sched.sv
// Read-domain burst scheduler for the async FIFO: RR burst grants, read pointer, empty, level.
// Ports: rclk, rrst (sync active-high), bus (slave modport: wptr_s/req/burst_len in, rest out).
module fifo_rd_burst_sched
    import fifo_rd_burst_sched_pkg::*;
#(
    parameter int Addr_Width = ADDR_W_DEF,
    parameter int NUM_REQ    = 2,
    parameter int BURST_W    = 4
) (
    input logic                  rclk,
    input logic                  rrst,
    fifo_rd_burst_sched_if.slave bus
);
    localparam int PW = Addr_Width + 1;

    sched_state_e       state_q, state_d;
    logic [BURST_W-1:0] cnt_q, cnt_d, len_sel;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] last_q, last_d;
    logic [NUM_REQ-1:0] own_q, own_d;
    logic [NUM_REQ-1:0] win;
    logic [PW-1:0]      rbin_q, rbin_d;
    logic [PW-1:0]      rptr_q, rptr_d;
    logic [PW-1:0]      lvl_q, lvl_d;
    logic               empty_q, empty_d;
    logic               vld_q;
    logic               ren;
    logic               last_rd;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i  (bus.req),
        .last_i (last_q),
        .gnt_o  (win)
    );

    assign ren     = (state_q == BURST) && !empty_q;
    assign last_rd = ren && (cnt_q == '0);

    always_comb begin
        len_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) len_sel = bus.burst_len[i*BURST_W +: BURST_W];
        end
    end

    // Empty and level use the current wptr_s so a write landing with the
    // last read keeps the FIFO non-empty without a bubble.
    assign rbin_d  = rbin_q + PW'(ren);
    assign rptr_d  = PW'(bin2gray(GW'(rbin_d)));
    assign empty_d = (rptr_d == bus.wptr_s);
    assign lvl_d   = PW'(gray2bin(GW'(bus.wptr_s))) - rbin_d;
    assign own_d   = ren ? grant_q : '0;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            last_q  <= NUM_REQ'(1) << (NUM_REQ - 1);
            rbin_q  <= '0;
            rptr_q  <= '0;
            empty_q <= 1'b1;
            lvl_q   <= '0;
            vld_q   <= 1'b0;
            own_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            rbin_q  <= rbin_d;
            rptr_q  <= rptr_d;
            empty_q <= empty_d;
            lvl_q   <= lvl_d;
            vld_q   <= ren;
            own_q   <= own_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (|bus.req) state_d = BURST;
            BURST: if (last_rd)  state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (state_q == IDLE) begin
            if (|bus.req) begin
                cnt_d   = len_sel;
                grant_d = win;
            end
        end else if (ren) begin
            cnt_d = cnt_q - BURST_W'(1);
            if (cnt_q == '0) begin
                grant_d = '0;
                last_d  = grant_q;
            end
        end
    end

    assign bus.grant    = grant_q;
    assign bus.ren      = ren;
    assign bus.raddr    = rbin_q[Addr_Width-1:0];
    assign bus.rptr     = rptr_q;
    assign bus.rempty   = empty_q;
    assign bus.rd_valid = vld_q;
    assign bus.rd_owner = own_q;
    assign bus.level    = lvl_q;
endmodule

// File: tb/tb_fifo_rd_burst_sched.sv
// Self-checking bench for fifo_rd_burst_sched (Addr_Width=9, NUM_REQ=2).
// Expected reads are queued as stimulus is applied and popped as the DUT reads.
module tb_fifo_rd_burst_sched;
    localparam int AW = 9;
    localparam int NR = 2;
    localparam int BW = 4;
    localparam int PW = AW + 1;
    localparam logic [1:0] GT [8] = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0};

    typedef struct {
        logic [NR-1:0] own;
        logic [AW-1:0] addr;
    } rd_t;

    logic clk = 1'b0;
    logic rrst = 1'b1;
    int n_chk = 0;
    int n_err = 0;
    rd_t exp_q[$];
    logic [NR-1:0] vq[$];
    rd_t e;
    logic [PW-1:0] wbin;
    int nrd;

    fifo_rd_burst_sched_if #(.Addr_Width(AW), .NUM_REQ(NR), .BURST_W(BW)) bus ();

    fifo_rd_burst_sched #(.Addr_Width(AW), .NUM_REQ(NR), .BURST_W(BW)) dut (
        .rclk (clk),
        .rrst (rrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] g(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Monitor: every read must match the next queued expectation, and
    // every rd_valid must follow a read by one cycle with the same owner.
    always @(negedge clk) begin
        if (bus.ren) begin
            if (exp_q.size() == 0) begin
                chk("stray_ren", 32'(bus.ren), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("raddr", 32'(bus.raddr), 32'(e.addr));
                chk("grant", 32'(bus.grant), 32'(e.own));
                vq.push_back(e.own);
            end
        end
        if (bus.rd_valid) begin
            if (vq.size() == 0) chk("stray_valid", 32'(bus.rd_valid), 32'(0));
            else chk("rd_owner", 32'(bus.rd_owner), 32'(vq.pop_front()));
        end
    end

    task automatic chk_rst(input string tag);
        chk({tag, "_rempty"}, 32'(bus.rempty), 32'(1));
        chk({tag, "_grant"}, 32'(bus.grant), 32'(0));
        chk({tag, "_ren"}, 32'(bus.ren), 32'(0));
        chk({tag, "_rptr"}, 32'(bus.rptr), 32'(0));
        chk({tag, "_level"}, 32'(bus.level), 32'(0));
        chk({tag, "_vld"}, 32'(bus.rd_valid), 32'(0));
        chk({tag, "_own"}, 32'(bus.rd_owner), 32'(0));
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        bus.req = '0;
        bus.wptr_s = '0;
        bus.burst_len = '0;
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        vq.delete();
        rrst = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || vq.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 32'(exp_q.size() + vq.size()), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.wptr_s = '0;
        bus.burst_len = '0;
        // Reset with both consumers requesting; consumer 0 wins first.
        rrst = 1'b1;
        bus.req = 2'b11;
        repeat (2) begin
            @(negedge clk);
            chk_rst("t1");
        end
        rrst = 1'b0;
        @(negedge clk);
        chk("t1_first_grant", 32'(bus.grant), 32'(1));

        // Single 4-word burst with 5 words available.
        do_reset();
        bus.wptr_s = g(10'd5);
        bus.req = 2'b01;
        bus.burst_len = 8'h03;
        for (int i = 0; i < 4; i++) exp_q.push_back('{2'b01, AW'(i)});
        @(negedge clk);
        chk("t2_grant", 32'(bus.grant), 32'(1));
        chk("t2_level0", 32'(bus.level), 32'(5));
        bus.req = '0;
        repeat (4) @(negedge clk);
        chk("t2_idle_grant", 32'(bus.grant), 32'(0));
        chk("t2_level", 32'(bus.level), 32'(1));
        chk("t2_rptr", 32'(bus.rptr), 32'(10'h006));
        chk("t2_rempty", 32'(bus.rempty), 32'(0));
        wait_drain(5);

        // Alternating single-word bursts with an idle bubble between.
        do_reset();
        bus.wptr_s = g(10'd100);
        bus.burst_len = 8'h00;
        bus.req = 2'b11;
        exp_q.push_back('{2'b01, AW'(0)});
        exp_q.push_back('{2'b10, AW'(1)});
        exp_q.push_back('{2'b01, AW'(2)});
        exp_q.push_back('{2'b10, AW'(3)});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t3_grant", 32'(bus.grant), 32'(GT[i]));
            chk("t3_ren", 32'(bus.ren), 32'(GT[i] != 2'd0));
            if (i == 6) bus.req = '0;
        end
        wait_drain(5);

        // Stall on empty mid-burst, then resume when more words arrive.
        do_reset();
        bus.wptr_s = g(10'd2);
        bus.req = 2'b01;
        bus.burst_len = 8'h03;
        for (int i = 0; i < 4; i++) exp_q.push_back('{2'b01, AW'(i)});
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        chk("t4_rempty", 32'(bus.rempty), 32'(1));
        chk("t4_ren", 32'(bus.ren), 32'(0));
        chk("t4_grant", 32'(bus.grant), 32'(1));
        @(negedge clk);
        chk("t4_ren_hold", 32'(bus.ren), 32'(0));
        chk("t4_grant_hold", 32'(bus.grant), 32'(1));
        bus.wptr_s = g(10'd4);
        @(negedge clk);
        chk("t4_resume", 32'(bus.ren), 32'(1));
        @(negedge clk);
        @(negedge clk);
        chk("t4_drop", 32'(bus.grant), 32'(0));
        chk("t4_empty", 32'(bus.rempty), 32'(1));
        chk("t4_level", 32'(bus.level), 32'(0));
        wait_drain(5);

        // Pointer wrap: 1280 reads in 16-word bursts alternating owners.
        do_reset();
        bus.burst_len = 8'hFF;
        bus.req = 2'b11;
        wbin = '0;
        nrd = 0;
        for (int ph = 0; ph < 5; ph++) begin
            wbin = wbin + PW'(256);
            bus.wptr_s = g(wbin);
            for (int j = 0; j < 256; j++) begin
                exp_q.push_back('{((nrd / 16) % 2 != 0) ? 2'b10 : 2'b01, AW'(nrd)});
                nrd++;
            end
            @(negedge clk);
            chk("t5_level_full", 32'(bus.level), 32'(256));
            chk("t5_nonempty", 32'(bus.rempty), 32'(0));
            wait_drain(400);
            chk("t5_rptr", 32'(bus.rptr), 32'(g(PW'(nrd))));
            chk("t5_rempty", 32'(bus.rempty), 32'(1));
            chk("t5_level", 32'(bus.level), 32'(0));
        end

        // Reset mid-burst with cnt=2.
        do_reset();
        bus.wptr_s = g(10'd10);
        bus.req = 2'b01;
        bus.burst_len = 8'h05;
        for (int i = 0; i < 4; i++) exp_q.push_back('{2'b01, AW'(i)});
        @(negedge clk);
        bus.req = '0;
        repeat (3) @(negedge clk);
        chk("t6_ren_before", 32'(bus.ren), 32'(1));
        rrst = 1'b1;
        @(negedge clk);
        chk_rst("t6");
        chk("t6_pending", 32'(vq.size()), 32'(1));
        vq.delete();
        rrst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("t6_vld", 32'(bus.rd_valid), 32'(0));
            chk("t6_ren", 32'(bus.ren), 32'(0));
        end
        chk("t6_queue", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
